phase_freq_detector: RTL and testbench

PHASE_FREQ_DETECTOR -- requirements
Module: phase_freq_detector

---
 rtl/phase_freq_detector.sv | 143 ++++++++++++++
 tb/tb_phase_freq_detector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/phase_freq_detector.sv
// ---------------------------------------------------------------------------
// phase_freq_detector
//
// Bang-bang phase/frequency detector. The reference (link) and the feedback
// oscillator (vco) are brought into the clk domain through a synchronizer
// chain. Their rising edges then drive a pair of mutually exclusive error
// pulses:
//   up : link rose first, so the oscillator has to speed up
//   dn : vco rose first, so the oscillator has to slow down
// A pulse ends when the lagging input's edge arrives. It also ends when it
// has been high for TIMEOUT clk cycles, so that a dead input cannot hold the
// loop at one rail indefinitely.
//
// Parameters
//   SYNC_STAGES : synchronizer depth on link and on vco (1..4)
//   TIMEOUT     : maximum pulse length in clk cycles (0 = no limit)
//
// Ports
//   clk     : system clock, rising-edge active
//   nrst    : synchronous reset, active-high
//   link    : reference input, asynchronous to clk
//   vco     : feedback oscillator input
//   setting : [0] pulse active (up|dn), [1] direction of last/current pulse
//             (1 = vco led, 0 = link led)
//   up, dn  : error pulses
//   upb,dnb : complements of up and dn
// ---------------------------------------------------------------------------
module phase_freq_detector #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       link,
  input  logic       vco,
  output logic [1:0] setting,
  output logic       up,
  output logic       dn,
  output logic       upb,
  output logic       dnb
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] link_sync_p0;
  logic [SYNC_STAGES-1:0] vco_sync_p0;
  logic                   link_dly_p0;
  logic                   vco_dly_p0;
  logic                   ru;
  logic                   rv;

  logic                   up_p1;
  logic                   dn_p1;
  logic                   act_p1;
  logic                   dir_p1;
  logic [CW-1:0]          cnt_p1;

  logic                   up_nxt;
  logic                   dn_nxt;
  logic                   act_nxt;
  logic                   dir_nxt;
  logic [CW-1:0]          cnt_nxt;
  logic                   u_req;
  logic                   d_req;
  logic                   timeout_hit;

  // ---- stage p0: synchronizers and rising-edge delay flops ----
  always_ff @(posedge clk) begin
    if (nrst) begin
      link_sync_p0 <= '0;
      vco_sync_p0  <= '0;
      link_dly_p0  <= 1'b0;
      vco_dly_p0   <= 1'b0;
    end else begin
      link_sync_p0[0] <= link;
      vco_sync_p0[0]  <= vco;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        link_sync_p0[i] <= link_sync_p0[i-1];
        vco_sync_p0[i]  <= vco_sync_p0[i-1];
      end
      link_dly_p0 <= link_sync_p0[SYNC_STAGES-1];
      vco_dly_p0  <= vco_sync_p0[SYNC_STAGES-1];
    end
  end

  assign ru = link_sync_p0[SYNC_STAGES-1] & ~link_dly_p0;
  assign rv = vco_sync_p0[SYNC_STAGES-1]  & ~vco_dly_p0;

  // ---- stage p1: pulse state, direction and pulse-width counter ----
  always_comb begin
    up_nxt      = 1'b0;
    dn_nxt      = 1'b0;
    dir_nxt     = dir_p1;
    cnt_nxt     = '0;
    u_req       = up_p1 | ru;
    d_req       = dn_p1 | rv;
    // cnt_p1 holds the number of edges seen since the pulse started, so the
    // edge that would make the pulse TIMEOUT+1 cycles long clears it instead.
    timeout_hit = (TIMEOUT != 0) && act_p1 && ((int'(cnt_p1) + 1) == TIMEOUT);

    // Both requests together means the lagging edge has arrived (or the two
    // edges coincided): either way there is no phase error left to report.
    if (!(u_req && d_req) && !timeout_hit) begin
      up_nxt = u_req;
      dn_nxt = d_req;
    end

    act_nxt = up_nxt | dn_nxt;

    // Direction only changes when a pulse starts from idle; it is remembered
    // after the pulse ends so software can see which side led last.
    if (!act_p1) begin
      if (up_nxt) dir_nxt = 1'b0;
      if (dn_nxt) dir_nxt = 1'b1;
    end

    if (act_nxt && act_p1) cnt_nxt = cnt_p1 + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      up_p1  <= 1'b0;
      dn_p1  <= 1'b0;
      act_p1 <= 1'b0;
      dir_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else begin
      up_p1  <= up_nxt;
      dn_p1  <= dn_nxt;
      act_p1 <= act_nxt;
      dir_p1 <= dir_nxt;
      cnt_p1 <= cnt_nxt;
    end
  end

  // ---- outputs: registers or their direct inversions only ----
  assign up      = up_p1;
  assign dn      = dn_p1;
  assign upb     = ~up_p1;
  assign dnb     = ~dn_p1;
  assign setting = {dir_p1, act_p1};

endmodule

// File: tb/tb_phase_freq_detector.sv
// ---------------------------------------------------------------------------
// tb_phase_freq_detector
//
// Two detectors share the same link/vco/nrst stimulus:
//   instance 0 : SYNC_STAGES=2, TIMEOUT=65535 (defaults)
//   instance 1 : SYNC_STAGES=3, TIMEOUT=8
// A behavioural model keeps, per instance, the history of sampled inputs and
// the state of the pulse, and predicts every output after every clk edge.
// Directed scenarios come first, followed by randomized input toggling with
// occasional resets.
// ---------------------------------------------------------------------------
module tb_phase_freq_detector;

  logic       clk;
  logic       nrst;
  logic       link;
  logic       vco;
  logic [1:0] a_setting, b_setting;
  logic       a_up, a_dn, a_upb, a_dnb;
  logic       b_up, b_dn, b_upb, b_dnb;

  int n_checks;
  int n_errors;

  phase_freq_detector dut_a (
    .clk(clk), .nrst(nrst), .link(link), .vco(vco),
    .setting(a_setting), .up(a_up), .dn(a_dn), .upb(a_upb), .dnb(a_dnb)
  );

  phase_freq_detector #(.SYNC_STAGES(3), .TIMEOUT(8)) dut_b (
    .clk(clk), .nrst(nrst), .link(link), .vco(vco),
    .setting(b_setting), .up(b_up), .dn(b_dn), .upb(b_upb), .dnb(b_dnb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---- reference model ----
  int         m_n[2]  = '{2, 3};
  int         m_to[2] = '{65535, 8};
  logic [7:0] hl[2];     // bit j = link as sampled j+1 edges ago
  logic [7:0] hv[2];
  logic       m_up[2];
  logic       m_dn[2];
  logic       m_dir[2];
  int         m_age[2];  // cycles the current pulse has been high

  task automatic model_step(input int i);
    logic el, ev, was, nu, nd;
    if (nrst) begin
      hl[i] = '0; hv[i] = '0;
      m_up[i] = 1'b0; m_dn[i] = 1'b0; m_dir[i] = 1'b0; m_age[i] = 0;
    end else begin
      // An edge is seen SYNC_STAGES edges after the input was first sampled high.
      el  = hl[i][m_n[i]-1] & ~hl[i][m_n[i]];
      ev  = hv[i][m_n[i]-1] & ~hv[i][m_n[i]];
      was = m_up[i] | m_dn[i];
      nu  = m_up[i] | el;
      nd  = m_dn[i] | ev;
      if (nu && nd) begin
        nu = 1'b0; nd = 1'b0;
      end else if (m_to[i] != 0 && was && m_age[i] == m_to[i]) begin
        nu = 1'b0; nd = 1'b0;
      end
      if (!was && nu) m_dir[i] = 1'b0;
      if (!was && nd) m_dir[i] = 1'b1;
      if (nu || nd) m_age[i] = was ? m_age[i] + 1 : 1;
      else          m_age[i] = 0;
      m_up[i] = nu;
      m_dn[i] = nd;
      hl[i] = {hl[i][6:0], link};
      hv[i] = {hv[i][6:0], vco};
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("a_up",      {31'd0, a_up},  {31'd0, m_up[0]});
    chk("a_dn",      {31'd0, a_dn},  {31'd0, m_dn[0]});
    chk("a_upb",     {31'd0, a_upb}, {31'd0, ~m_up[0]});
    chk("a_dnb",     {31'd0, a_dnb}, {31'd0, ~m_dn[0]});
    chk("a_setting", {30'd0, a_setting}, {30'd0, m_dir[0], m_up[0] | m_dn[0]});
    chk("b_up",      {31'd0, b_up},  {31'd0, m_up[1]});
    chk("b_dn",      {31'd0, b_dn},  {31'd0, m_dn[1]});
    chk("b_upb",     {31'd0, b_upb}, {31'd0, ~m_up[1]});
    chk("b_dnb",     {31'd0, b_dnb}, {31'd0, ~m_dn[1]});
    chk("b_setting", {30'd0, b_setting}, {30'd0, m_dir[1], m_up[1] | m_dn[1]});
    if (a_up && a_dn) chk("a_overlap", 32'd1, 32'd0);
    if (b_up && b_dn) chk("b_overlap", 32'd1, 32'd0);
  endtask

  int a_up_cycles;
  int b_up_cycles;

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_outputs();
    if (a_up) a_up_cycles++;
    if (b_up) b_up_cycles++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    a_up_cycles = 0;
    b_up_cycles = 0;
    nrst = 1'b1;
    link = 1'b0;
    vco  = 1'b0;

    // Reset with both inputs toggling
    for (int k = 0; k < 2; k++) begin
      link = ~link;
      vco  = ~vco;
      tick();
      chk("rst_a_setting", {30'd0, a_setting}, 32'd0);
      chk("rst_b_upb",     {31'd0, b_upb},     32'd1);
    end
    link = 1'b0; vco = 1'b0; nrst = 1'b0;
    idle(8);

    // Link leads vco by 15 cycles
    a_up_cycles = 0; b_up_cycles = 0;
    link = 1'b1;
    idle(15);
    vco = 1'b1;
    idle(12);
    chk("a_up_width", a_up_cycles, 32'd15);
    chk("b_up_timeout_width", b_up_cycles, 32'd8);
    chk("a_dir_link_led", {31'd0, a_setting[1]}, 32'd0);

    // Vco leads link by 4 cycles
    link = 1'b0; vco = 1'b0;
    idle(12);
    vco = 1'b1;
    idle(4);
    link = 1'b1;
    idle(8);
    chk("a_dir_vco_led", {30'd0, a_setting}, 32'd2);

    // Simultaneous edges: no pulse, direction kept
    link = 1'b0; vco = 1'b0;
    idle(12);
    link = 1'b1; vco = 1'b1;
    idle(8);
    chk("a_simul_setting", {30'd0, a_setting}, 32'd2);

    // Timeout restart on a second link edge with vco static
    link = 1'b0; vco = 1'b1;
    idle(12);
    b_up_cycles = 0;
    link = 1'b1;
    idle(14);
    link = 1'b0;
    idle(2);
    link = 1'b1;
    idle(14);
    chk("b_up_restart_width", b_up_cycles, 32'd16);

    // Reset in the middle of a pulse
    link = 1'b0; vco = 1'b0;
    idle(12);
    link = 1'b1;
    idle(5);
    nrst = 1'b1;
    tick();
    chk("a_rst_mid_pulse_up", {31'd0, a_up}, 32'd0);
    nrst = 1'b0; link = 1'b0;
    idle(10);

    // Randomized toggling with occasional reset
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 5) == 0) link = ~link;
      if ($urandom_range(0, 5) == 0) vco  = ~vco;
      nrst = ($urandom_range(0, 249) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
